// File: rtl/ram_pkg.sv
// ram_pkg: shared constants, state encoding and byte-merge helper for ram_sdp
package ram_pkg;
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;
    localparam int MAX_W = 1024;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w,
                                                    input logic [MAX_W-1:0] new_w,
                                                    input logic [MAX_W/8-1:0] be);
        byte_merge = old_w;
        for (int i = 0; i < MAX_W/8; i++)
            if (be[i]) byte_merge[8*i +: 8] = new_w[8*i +: 8];
    endfunction
endpackage

// File: rtl/ram_sdp.sv
// ram_sdp: simple dual-port RAM with byte-enable writes, registered read with valid,
// selectable read-during-write result and an optional post-reset clear sweep.
module ram_sdp
    import ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter int RDW_MODE       = RDW_OLD,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wren,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [DATA_W/8-1:0] w_be,
    input  logic              rden,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              busy
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;

    generate
        if (DATA_W % 8 != 0 || DATA_W > MAX_W) begin : g_chk
            $error("ram_sdp: DATA_W must be a multiple of 8 and at most MAX_W");
        end
    endgenerate

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic              w_clr, w_wr, w_rd, w_rdw;
    logic [DATA_W-1:0] w_merged;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_clr ? r_cnt + 1'b1 : r_cnt;
        end
    end

    always_comb begin
        w_state_nxt = (r_state == ST_CLEAR && r_cnt == ADDR_W'(DEPTH-1)) ? ST_RUN : r_state;
    end

    always_comb begin
        busy     = r_state == ST_CLEAR;
        w_clr    = !rst && busy;
        w_wr     = !rst && !busy && wren;
        w_rd     = !busy && rden;
        w_rdw    = RDW_MODE == RDW_NEW && w_wr && w_addr == r_addr;
        w_merged = DATA_W'(byte_merge(MAX_W'(r_mem[r_addr]), MAX_W'(w_data), (MAX_W/8)'(w_be)));
    end

    // Lane-wise writes keep the byte-write RAM template recognisable to synthesis
    always_ff @(posedge clk) begin
        if (w_clr)
            r_mem[r_cnt] <= '0;
        else if (w_wr)
            for (int i = 0; i < NB; i++)
                if (w_be[i]) r_mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd;
            if (w_rd) r_data <= w_rdw ? w_merged : r_mem[r_addr];
        end
    end
endmodule

// File: tb/tb_ram_sdp.sv
// tb_ram_sdp: scoreboard bench for ram_sdp, one old-data and one new-data RDW instance
module tb_ram_sdp;
    logic        clk = 1'b0, rst = 1'b1, wren = 1'b0, rden = 1'b0;
    logic [4:0]  w_addr = '0, r_addr = '0;
    logic [31:0] w_data = '0;
    logic [3:0]  w_be = '0;
    logic [31:0] a_data, b_data;
    logic        a_valid, b_valid, a_busy, b_busy;
    int          total = 0, bad = 0;
    logic [31:0] model [32];
    logic [31:0] qa [$];
    logic [31:0] qb [$];
    logic [31:0] ea, eb;

    always #5 clk = ~clk;

    ram_sdp #(.DATA_W(32), .ADDR_W(5), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .rst(rst), .wren(wren), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
        .rden(rden), .r_addr(r_addr), .r_data(a_data), .r_valid(a_valid), .busy(a_busy));

    ram_sdp #(.DATA_W(32), .ADDR_W(5), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .rst(rst), .wren(wren), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
        .rden(rden), .r_addr(r_addr), .r_data(b_data), .r_valid(b_valid), .busy(b_busy));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wren = 1'b0;
        rden = 1'b0;
        w_be = '0;
    endtask

    task automatic merge_model(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int i = 0; i < 4; i++)
            if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wren = 1'b1; w_addr = a; w_data = d; w_be = be;
        merge_model(a, d, be);
        step;
        wren = 1'b0;
    endtask

    task automatic issue_read(input logic [4:0] a);
        rden = 1'b1;
        r_addr = a;
        qa.push_back(model[a]);
        qb.push_back(model[a]);
    endtask

    task automatic test_reset_sweep;
        int n;
        idle;
        rst = 1'b1;
        step;
        total++;
        if (a_data !== 32'h0 || a_valid !== 1'b0 || a_busy !== 1'b1 || b_busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_state got data=%h valid=%b busy=%b/%b want 0 0 1/1", a_data, a_valid, a_busy, b_busy);
        end
        rst = 1'b0;
        n = 0;
        while (a_busy && n < 100) begin
            step;
            n++;
        end
        total++;
        if (n !== 32 || b_busy !== 1'b0) begin
            bad++;
            $display("FAIL sweep_len got=%0d b_busy=%b want=32 0", n, b_busy);
        end
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int i = 0; i < 32; i++) begin
            issue_read(5'(i));
            step;
            ea = qa.pop_front();
            eb = qb.pop_front();
            total++;
            if (a_valid !== 1'b1 || a_data !== ea || b_valid !== 1'b1 || b_data !== eb) begin
                bad++;
                $display("FAIL sweep_read[%0d] got=%h/%h v=%b/%b want=%h/%h v=1", i, a_data, b_data, a_valid, b_valid, ea, eb);
            end
        end
        idle;
    endtask

    task automatic test_byte_en;
        wr(5'd3, 32'hDEADBEEF, 4'hF);
        wr(5'd3, 32'h11223344, 4'b0101);
        issue_read(5'd3);
        step;
        idle;
        ea = qa.pop_front();
        eb = qb.pop_front();
        total++;
        if (a_valid !== 1'b1 || a_data !== ea || b_data !== eb) begin
            bad++;
            $display("FAIL byte_en got=%h/%h v=%b want=%h", a_data, b_data, a_valid, ea);
        end
    endtask

    task automatic test_rdw;
        wr(5'd7, 32'hAAAAAAAA, 4'hF);
        wren = 1'b1; w_addr = 5'd7; w_data = 32'h55555555; w_be = 4'b0011;
        rden = 1'b1; r_addr = 5'd7;
        qa.push_back(model[7]);
        merge_model(5'd7, 32'h55555555, 4'b0011);
        qb.push_back(model[7]);
        step;
        idle;
        ea = qa.pop_front();
        eb = qb.pop_front();
        total++;
        if (a_valid !== 1'b1 || a_data !== ea) begin
            bad++;
            $display("FAIL rdw_old got=%h want=%h", a_data, ea);
        end
        total++;
        if (b_valid !== 1'b1 || b_data !== eb) begin
            bad++;
            $display("FAIL rdw_new got=%h want=%h", b_data, eb);
        end
        // read 7 while writing 9: independent ports
        wren = 1'b1; w_addr = 5'd9; w_data = 32'hCAFEF00D; w_be = 4'hF;
        issue_read(5'd7);
        merge_model(5'd9, 32'hCAFEF00D, 4'hF);
        step;
        issue_read(5'd9);
        wren = 1'b0;
        ea = qa.pop_front();
        eb = qb.pop_front();
        total++;
        if (a_data !== ea || b_data !== eb || a_valid !== 1'b1) begin
            bad++;
            $display("FAIL rdw_after got=%h/%h want=%h/%h", a_data, b_data, ea, eb);
        end
        step;
        idle;
        ea = qa.pop_front();
        eb = qb.pop_front();
        total++;
        if (a_data !== ea || b_data !== eb || b_valid !== 1'b1) begin
            bad++;
            $display("FAIL diff_addr got=%h/%h want=%h/%h", a_data, b_data, ea, eb);
        end
    endtask

    task automatic test_hold_throughput;
        for (int i = 0; i < 32; i++) wr(5'(i), 32'(i * 3), 4'hF);
        for (int i = 0; i < 32; i++) begin
            issue_read(5'(i));
            step;
            ea = qa.pop_front();
            eb = qb.pop_front();
            total++;
            if (a_valid !== 1'b1 || a_data !== ea || b_valid !== 1'b1 || b_data !== eb) begin
                bad++;
                $display("FAIL thru[%0d] got=%h/%h v=%b/%b want=%h", i, a_data, b_data, a_valid, b_valid, ea);
            end
        end
        idle;
        step;
        total++;
        if (a_valid !== 1'b0 || a_data !== model[31] || b_valid !== 1'b0 || b_data !== model[31]) begin
            bad++;
            $display("FAIL hold got=%h/%h v=%b/%b want=%h v=0", a_data, b_data, a_valid, b_valid, model[31]);
        end
    endtask

    task automatic test_reset_mid_sweep;
        int n;
        rst = 1'b1;
        step;
        total++;
        if (a_data !== 32'h0 || a_valid !== 1'b0 || b_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_clears got=%h/%h v=%b want=0", a_data, b_data, a_valid);
        end
        rst = 1'b0;
        for (int i = 0; i < 19; i++) step;
        rst = 1'b1;
        step;
        total++;
        if (a_data !== 32'h0 || a_valid !== 1'b0 || a_busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset got data=%h valid=%b busy=%b want 0 0 1", a_data, a_valid, a_busy);
        end
        rst = 1'b0;
        n = 0;
        while (a_busy && n < 100) begin
            step;
            n++;
        end
        total++;
        if (n !== 32) begin
            bad++;
            $display("FAIL mid_sweep_len got=%0d want=32", n);
        end
        for (int i = 0; i < 32; i++) model[i] = '0;
        issue_read(5'd31);
        step;
        idle;
        ea = qa.pop_front();
        eb = qb.pop_front();
        total++;
        if (a_data !== ea || b_data !== eb || a_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_cleared got=%h/%h want=%h", a_data, b_data, ea);
        end
    endtask

    task automatic test_busy_lockout;
        int n;
        rst = 1'b1;
        step;
        rst = 1'b0;
        rden = 1'b1; r_addr = 5'd0;
        w_addr = 5'd0; w_data = 32'h12345678; w_be = 4'hF;
        n = 0;
        while (a_busy && n < 100) begin
            wren = (n == 4);
            step;
            n++;
            total++;
            if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
                bad++;
                $display("FAIL busy_valid[%0d] got=%b/%b want=0", n, a_valid, b_valid);
            end
        end
        idle;
        total++;
        if (n !== 32) begin
            bad++;
            $display("FAIL lockout_len got=%0d want=32", n);
        end
        issue_read(5'd0);
        step;
        idle;
        ea = qa.pop_front();
        eb = qb.pop_front();
        total++;
        if (a_data !== ea || b_data !== eb || a_valid !== 1'b1) begin
            bad++;
            $display("FAIL lockout_read got=%h/%h want=%h", a_data, b_data, ea);
        end
    endtask

    initial begin
        test_reset_sweep;
        test_byte_en;
        test_rdw;
        test_hold_throughput;
        test_reset_mid_sweep;
        test_busy_lockout;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end
endmodule
